// File: rtl/resp_encoder.sv
// Response packet encoder: serialises status and command-acknowledge packets
// onto a byte link with valid/ready handshake and an XOR checksum trailer.
module resp_encoder #(
  parameter logic [7:0] STATUS_HDR = 8'hA7,
  parameter logic [7:0] ACK_HDR    = 8'hA1
) (
  input  logic       CLK,
  input  logic       rst_n,
  input  logic [7:0] CMD,
  input  logic [7:0] BUSY,
  input  logic [7:0] DONE,
  input  logic       tx_ready,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  output logic       tx_last,
  output logic       resp_busy
);

  typedef enum logic [2:0] {IDLE, HDR, P0, P1, CHK} state_t;

  state_t     r_state;
  logic       r_stat_pend;
  logic [6:0] r_ack_pend;
  logic [7:0] r_done_sticky;
  logic [7:0] r_bsnap;
  logic [7:0] r_dsnap;
  logic [7:0] r_op;
  logic       r_is_stat;
  logic [7:0] r_tx_data;
  logic       r_tx_valid;
  logic       r_tx_last;
  logic       r_resp_busy;

  logic       w_start_stat;
  logic       w_start_ack;
  logic       w_acc;
  logic [7:0] w_ack_op;
  logic [6:0] w_ack_clr;

  // Descending scan so the lowest set index is the one left selected.
  always_comb begin
    w_ack_op  = 8'd0;
    w_ack_clr = 7'd0;
    for (int i = 6; i >= 0; i--) begin
      if (r_ack_pend[i]) begin
        w_ack_op  = 8'(i + 1);
        w_ack_clr = 7'd1 << i;
      end
    end
  end

  assign w_start_stat = (r_state == IDLE) && r_stat_pend;
  assign w_start_ack  = (r_state == IDLE) && !r_stat_pend && (r_ack_pend != 7'd0);
  assign w_acc        = r_tx_valid && tx_ready;

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_stat_pend   <= 1'b0;
      r_ack_pend    <= 7'd0;
      r_done_sticky <= 8'd0;
      r_bsnap       <= 8'd0;
      r_dsnap       <= 8'd0;
      r_op          <= 8'd0;
      r_is_stat     <= 1'b0;
      r_tx_data     <= 8'd0;
      r_tx_valid    <= 1'b0;
      r_tx_last     <= 1'b0;
      r_resp_busy   <= 1'b0;
    end else begin
      // Clear-on-select first, then OR in new strobes so a same-cycle strobe wins.
      r_stat_pend <= (r_stat_pend & ~w_start_stat) | CMD[7];
      r_ack_pend  <= (r_ack_pend & ~(w_start_ack ? w_ack_clr : 7'd0)) | CMD[6:0];
      if (w_start_stat) begin
        r_bsnap       <= BUSY;
        r_dsnap       <= r_done_sticky;
        r_done_sticky <= DONE;
      end else begin
        r_done_sticky <= r_done_sticky | DONE;
      end

      case (r_state)
        IDLE: if (w_start_stat || w_start_ack) begin
          r_state     <= HDR;
          r_is_stat   <= w_start_stat;
          r_op        <= w_ack_op;
          r_tx_valid  <= 1'b1;
          r_tx_last   <= 1'b0;
          r_tx_data   <= w_start_stat ? STATUS_HDR : ACK_HDR;
          r_resp_busy <= 1'b1;
        end
        HDR: if (w_acc) begin
          r_state   <= P0;
          r_tx_data <= r_is_stat ? r_bsnap : r_op;
        end
        P0: if (w_acc) begin
          if (r_is_stat) begin
            r_state   <= P1;
            r_tx_data <= r_dsnap;
          end else begin
            r_state   <= CHK;
            r_tx_data <= ACK_HDR ^ r_op;
            r_tx_last <= 1'b1;
          end
        end
        P1: if (w_acc) begin
          r_state   <= CHK;
          r_tx_data <= STATUS_HDR ^ r_bsnap ^ r_dsnap;
          r_tx_last <= 1'b1;
        end
        CHK: if (w_acc) begin
          r_state     <= IDLE;
          r_tx_valid  <= 1'b0;
          r_tx_last   <= 1'b0;
          r_tx_data   <= 8'd0;
          r_resp_busy <= 1'b0;
        end
        default: begin
          r_state     <= IDLE;
          r_tx_valid  <= 1'b0;
          r_tx_last   <= 1'b0;
          r_tx_data   <= 8'd0;
          r_resp_busy <= 1'b0;
        end
      endcase
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign tx_last   = r_tx_last;
  assign resp_busy = r_resp_busy;

endmodule
